// File: rtl/display_share_arbiter_pkg.sv
// Shared types and constants for the display share arbiter.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   localparam int DIGIT_W = 8;
   localparam logic [DIGIT_W-1:0] BLANK_SEG = 8'h00;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/display_share_arbiter_if.sv
// Requester/display side signals of the display share arbiter.
interface display_share_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]                      Req;
   logic [NUM_REQ*display_pkg::DIGIT_W-1:0] ReqValue;
   logic [NUM_REQ-1:0]                      Grant;
   logic [NUM_REQ-1:0]                      Done;
   logic [display_pkg::DIGIT_W-1:0]         Value;
   logic                                    Blank;
   logic                                    Busy;

   modport master (output Req, ReqValue, input Grant, Done, Value, Blank, Busy);
   modport slave  (input Req, ReqValue, output Grant, Done, Value, Blank, Busy);
endinterface

// File: rtl/display_share_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               any
);
   int               idx;
   logic [PTR_W-1:0] sel;
   logic             found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = idx[PTR_W-1:0];
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/display_share_arbiter.sv
// Time-shares the two-digit display between requesters: round-robin owner,
// fixed dwell while others wait, blank gap on every hand-over.
module display_share_arbiter
   import display_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DWELL_CYCLES = 8,
   parameter int BLANK_CYCLES = 2
) (
   input logic                    Clock,
   input logic                    Reset_n,
   display_share_arbiter_if.slave bus
);
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_MAX = max2(DWELL_CYCLES, BLANK_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [DIGIT_W-1:0]   value_q, value_d;
   logic                 blank_q, blank_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   // hand-over cycle: owner released, Grant=0, arbitration happens at its end
   logic                 hand_q, hand_d;

   logic [NUM_REQ-1:0]   win_oh;
   logic                 win_any;
   logic [PTR_W-1:0]     win_idx, ptr_after;
   logic [DIGIT_W-1:0]   lane;
   logic                 owner_req, others_req;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .req (bus.Req),
      .ptr (ptr_q),
      .gnt (win_oh),
      .any (win_any)
   );

   always_comb begin
      win_idx = '0;
      lane    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) win_idx = PTR_W'(i);
         lane = lane | ({DIGIT_W{grant_q[i]}} & bus.ReqValue[DIGIT_W*i +: DIGIT_W]);
      end
   end

   assign ptr_after  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
   assign owner_req  = |(bus.Req & grant_q);
   assign others_req = |(bus.Req & ~grant_q);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      value_d = value_q;
      blank_d = blank_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      hand_d  = hand_q;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d = BLANK;
               grant_d = win_oh;
               ptr_d   = ptr_after;
               cnt_d   = '0;
            end
         end
         BLANK: begin
            if (hand_q) begin
               hand_d = 1'b0;
               if (win_any) begin
                  grant_d = win_oh;
                  ptr_d   = ptr_after;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (!owner_req) begin
               grant_d = '0;
               hand_d  = 1'b1;
            end else if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               blank_d = 1'b0;
               value_d = lane;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SHOW: begin
            if (!owner_req || (cnt_q == DWELL_LAST && others_req)) begin
               state_d = BLANK;
               grant_d = '0;
               done_d  = grant_q;
               blank_d = 1'b1;
               hand_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               value_d = lane;
               cnt_d   = (cnt_q == DWELL_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         value_q <= BLANK_SEG;
         blank_q <= 1'b1;
         ptr_q   <= '0;
         cnt_q   <= '0;
         hand_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         value_q <= value_d;
         blank_q <= blank_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         hand_q  <= hand_d;
      end
   end

   assign bus.Grant = grant_q;
   assign bus.Done  = done_q;
   assign bus.Value = value_q;
   assign bus.Blank = blank_q;
   assign bus.Busy  = (state_q != IDLE);

endmodule
